adxl362_clock_controller: RTL and testbench

Synthesizable, parametrised successor to the behavioural free-running 51.2 kHz system clock used by the ADXL362 environment. From one fast clock it derives a base 51.2 kHz tick plus NUM_CH independently programmable sample-rate ticks (ODR-style: 400, 200, 100 … Hz), and a stretched power-on reset. It sits at the top of the PmodACL2 design, feeding sample strobes to the SPI sequencer and its model.

---
 rtl/adxl362_clk_pkg.sv | 22 ++
 rtl/adxl362_tick_divider.sv | 34 +++
 rtl/adxl362_clock_controller.sv | 107 ++++++++++
 tb/tb_adxl362_clock_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adxl362_clk_pkg.sv
// rtl/adxl362_clk_pkg.sv - shared state encoding and rate constants for the ADXL362 clock controller
package adxl362_clk_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } clk_state_t;

  // 100 MHz / 1953 gives the 51.2 kHz base rate
  localparam int DEFAULT_BASE_DIV = 1953;

  // Base-tick divide ratios for the ADXL362 output data rates
  localparam int ODR_400HZ  = 128;
  localparam int ODR_200HZ  = 256;
  localparam int ODR_100HZ  = 512;
  localparam int ODR_50HZ   = 1024;
  localparam int ODR_25HZ   = 2048;
  // Needs a divider field of at least 13 bits
  localparam int ODR_12P5HZ = 4096;

endpackage

// File: rtl/adxl362_tick_divider.sv
// rtl/adxl362_tick_divider.sv - one sample-rate channel counting base wraps
module adxl362_tick_divider #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             hit;

  // Greater-or-equal compare lets a lowered ratio fire at the next wrap and keeps cnt bounded
  assign hit = (div != '0) && (cnt >= (div - 1'b1));

  // Count base wraps; the tick is still emitted on a wrap that coincides with a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= advance && hit;
      if (clear) begin
        cnt <= '0;
      end else if (advance) begin
        cnt <= (hit || (div == '0)) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adxl362_clock_controller.sv
// rtl/adxl362_clock_controller.sv - base tick, per-channel sample ticks and stretched reset
module adxl362_clock_controller
  import adxl362_clk_pkg::*;
#(
  parameter int BASE_DIV   = DEFAULT_BASE_DIV,
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = 12,
  parameter int RESET_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic                    base_tick,
  output logic [NUM_CH-1:0]       ch_tick,
  output logic                    sys_rst,
  output logic                    ready
);

  localparam int BASE_W = $clog2(BASE_DIV);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  clk_state_t        state_q;
  clk_state_t        state_d;
  logic [BASE_W-1:0] base_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              en_q;
  logic              wrap;
  logic              run_wrap;
  logic              ch_clear;

  assign wrap     = (base_cnt == BASE_LAST);
  assign run_wrap = (state_q == ST_RUN) && wrap;
  assign ch_clear = (state_d != ST_RUN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave HOLD on the last wrap of the hold, follow the registered enable otherwise
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: if (wrap && (hold_cnt == HOLD_LAST)) state_d = ST_IDLE;
      ST_IDLE: if (en_q) state_d = ST_RUN;
      ST_RUN:  if (!en_q) state_d = ST_IDLE;
      default: state_d = ST_HOLD;
    endcase
  end

  // Base/hold counters, base strobe and the stretched reset outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      base_cnt  <= '0;
      hold_cnt  <= '0;
      en_q      <= 1'b0;
      base_tick <= 1'b0;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
    end else begin
      en_q      <= enable;
      base_tick <= run_wrap;
      case (state_q)
        ST_HOLD: begin
          if (state_d == ST_IDLE) begin
            base_cnt <= '0;
            hold_cnt <= '0;
            sys_rst  <= 1'b0;
            ready    <= 1'b1;
          end else begin
            base_cnt <= wrap ? '0 : base_cnt + 1'b1;
            if (wrap) hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          base_cnt <= (wrap || (state_d != ST_RUN)) ? '0 : base_cnt + 1'b1;
          hold_cnt <= '0;
        end
        default: begin
          base_cnt <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    adxl362_tick_divider #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk     (clk),
      .rst     (rst),
      .advance (run_wrap),
      .clear   (ch_clear),
      .div     (ch_div[g*DIV_W +: DIV_W]),
      .tick    (ch_tick[g])
    );
  end

endmodule

// File: tb/tb_adxl362_clock_controller.sv
// tb/tb_adxl362_clock_controller.sv - randomized self-checking bench for the clock controller
module tb_adxl362_clock_controller;

  localparam int BASE_DIV   = 4;
  localparam int NUM_CH     = 2;
  localparam int DIV_W      = 4;
  localparam int RESET_HOLD = 2;
  localparam int HOLD_CYC   = RESET_HOLD * BASE_DIV;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic [NUM_CH*DIV_W-1:0] ch_div;
  logic                    base_tick;
  logic [NUM_CH-1:0]       ch_tick;
  logic                    sys_rst;
  logic                    ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: mode 0=hold 1=idle 2=run, time in RUN kept as an age in edges
  int                m_mode = 0;
  int                m_hold_edges = 0;
  int                m_age = 0;
  bit                m_en_prev = 0;
  int                m_cnt [NUM_CH];
  bit                e_base = 0;
  logic [NUM_CH-1:0] e_ch = '0;
  bit                e_sys = 1;
  bit                e_ready = 0;

  adxl362_clock_controller #(
    .BASE_DIV   (BASE_DIV),
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .RESET_HOLD (RESET_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ch_div    (ch_div),
    .base_tick (base_tick),
    .ch_tick   (ch_tick),
    .sys_rst   (sys_rst),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit r, input bit en, input logic [NUM_CH*DIV_W-1:0] div);
    int d;
    e_base = 0;
    e_ch   = '0;
    if (r) begin
      m_mode = 0; m_hold_edges = 0; m_age = 0; m_en_prev = 0;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      e_sys = 1; e_ready = 0;
      return;
    end
    case (m_mode)
      0: begin
        m_hold_edges++;
        if (m_hold_edges == HOLD_CYC) begin
          m_mode = 1; e_sys = 0; e_ready = 1;
        end
      end
      1: begin
        if (m_en_prev) begin
          m_mode = 2; m_age = 0;
        end
      end
      default: begin
        m_age++;
        if (m_age % BASE_DIV == 0) begin
          e_base = 1;
          for (int i = 0; i < NUM_CH; i++) begin
            d = int'(div[i*DIV_W +: DIV_W]);
            if (d == 0) m_cnt[i] = 0;
            else if (m_cnt[i] >= d - 1) begin
              e_ch[i] = 1'b1; m_cnt[i] = 0;
            end else m_cnt[i]++;
          end
        end
        if (!m_en_prev) begin
          m_mode = 1;
          for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        end
      end
    endcase
    m_en_prev = en;
  endtask

  task automatic step();
    model_edge(rst, enable, ch_div);
    @(posedge clk);
    cyc++;
    #1;
    check("base_tick", 32'(base_tick), 32'(e_base));
    check("ch_tick", 32'(ch_tick), 32'(e_ch));
    check("sys_rst", 32'(sys_rst), 32'(e_sys));
    check("ready", 32'(ready), 32'(e_ready));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic first_tick_latency(output int lat);
    int t;
    t = cyc + 1;
    step();
    lat = 0;
    for (int k = 0; k < 30 && !base_tick; k++) step();
    lat = cyc - t;
  endtask

  initial begin
    int n;
    int lat;
    int c0;
    int c1;
    int nb;
    bit found;
    rst = 1'b1; enable = 1'b0; ch_div = '0;
    @(negedge clk);

    // reset hold
    step();
    check("reset_sys_rst", 32'(sys_rst), 32'd1);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_base_tick", 32'(base_tick), 32'd0);
    step(); step();
    rst = 1'b0;
    wait_ready(n);
    check("hold_len", n, HOLD_CYC);
    for (int k = 0; k < 6; k++) step();

    // basic run, ch0 every base tick, ch1 every third
    ch_div = {4'd3, 4'd1};
    enable = 1'b1;
    first_tick_latency(lat);
    check("first_latency", lat, BASE_DIV + 1);
    for (int k = 0; k < 40; k++) step();

    // ch1 disabled for 20 base periods
    ch_div = {4'd0, 4'd1};
    c0 = 0; c1 = 0; nb = 0;
    for (int k = 0; k < 20 * BASE_DIV; k++) begin
      step();
      nb += int'(base_tick); c0 += int'(ch_tick[0]); c1 += int'(ch_tick[1]);
    end
    check("disabled_ch1", c1, 0);
    check("ch0_follows_base", c0, nb);
    check("base_count_20", nb, 20);

    // ratio lowered 5 -> 2 while ch1 count is 3
    ch_div = {4'd5, 4'd1};
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      if (e_base && m_cnt[1] == 3) found = 1;
    end
    check("reach_cnt3", 32'(found), 32'd1);
    ch_div = {4'd2, 4'd1};
    step();
    for (int k = 0; k < 10 && !base_tick; k++) step();
    check("lowered_next_tick", 32'(ch_tick[1]), 32'd1);
    for (int k = 0; k < 30; k++) step();

    // enable drop timed so the exit edge is a wrap
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_mode == 2 && (m_age % BASE_DIV) == BASE_DIV - 2) found = 1;
      else step();
    end
    check("drop_align", 32'(found), 32'd1);
    enable = 1'b0;
    step();
    step();
    check("drop_tick_emitted", 32'(base_tick), 32'd1);
    nb = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      nb += int'(base_tick) + int'(|ch_tick);
    end
    check("silent_after_drop", nb, 0);
    enable = 1'b1;
    first_tick_latency(lat);
    check("restart_latency", lat, BASE_DIV + 1);
    for (int k = 0; k < 9; k++) step();

    // reset during RUN
    rst = 1'b1;
    step();
    check("midrst_sys_rst", 32'(sys_rst), 32'd1);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_ticks", 32'({base_tick, ch_tick}), 32'd0);
    rst = 1'b0;
    wait_ready(n);
    check("midrst_hold_len", n, HOLD_CYC);

    // random soak
    for (int k = 0; k < 600; k++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0)
        ch_div = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
